// File: rtl/obi_memory_arbiter.sv
// Two-port OBI arbiter sharing one memory port: fixed priority to port 0, in-order response routing.
// Optional macro OBI_MEMORY_ARBITER_ROUND_ROBIN_EN alternates priority when both ports request.
module obi_memory_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [1:0]                          req_i,
   output logic [1:0]                          gnt_o,
   input  logic [1:0][ADDR_WIDTH-1:0]          addr_i,
   input  logic [1:0]                          we_i,
   input  logic [1:0][DATA_WIDTH/8-1:0]        be_i,
   input  logic [1:0][DATA_WIDTH-1:0]          wdata_i,
   output logic [1:0]                          rvalid_o,
   output logic [DATA_WIDTH-1:0]               rdata_o,
   output logic                                err_o,
   output logic                                mem_req_o,
   input  logic                                mem_gnt_i,
   output logic [ADDR_WIDTH-1:0]               mem_addr_o,
   output logic                                mem_we_o,
   output logic [DATA_WIDTH/8-1:0]             mem_be_o,
   output logic [DATA_WIDTH-1:0]               mem_wdata_o,
   input  logic                                mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]               mem_rdata_i,
   input  logic                                mem_err_i,
   output logic                                protocol_err_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic             sel_q, sel_d, sel;
   logic             locked_q, locked_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic             id_q [MAX_OUTSTANDING];
   logic             protocol_err_q;
   logic             full, mem_req, accept, pop, head;
`ifdef OBI_MEMORY_ARBITER_ROUND_ROBIN_EN
   logic             prio_q;
`endif

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full = (count_q == CNT_W'(MAX_OUTSTANDING));

   // A stalled address phase keeps its port until granted or withdrawn.
   always_comb begin
      sel = ~req_i[0];
      if (locked_q) begin
         sel = sel_q;
      end
`ifdef OBI_MEMORY_ARBITER_ROUND_ROBIN_EN
      else if (&req_i) begin
         sel = prio_q;
      end
`endif
   end

   assign mem_req  = req_i[sel] & ~full;
   assign accept   = mem_req & mem_gnt_i;
   assign pop      = mem_rvalid_i & (count_q != '0);
   assign head     = id_q[rptr_q];
   assign locked_d = mem_req & ~mem_gnt_i;
   assign sel_d    = sel;

   always_comb begin
      count_d = count_q;
      if (accept && !pop) count_d = count_q + CNT_W'(1);
      else if (pop && !accept) count_d = count_q - CNT_W'(1);
   end

   // Every output is forced low while reset is held, even with requests pending.
   assign mem_req_o      = rst_ni & mem_req;
   assign gnt_o          = (rst_ni & accept) ? (sel ? 2'b10 : 2'b01) : 2'b00;
   assign mem_addr_o     = rst_ni ? addr_i[sel]  : '0;
   assign mem_we_o       = rst_ni & we_i[sel];
   assign mem_be_o       = rst_ni ? be_i[sel]    : '0;
   assign mem_wdata_o    = rst_ni ? wdata_i[sel] : '0;
   assign rvalid_o       = (rst_ni & pop) ? (head ? 2'b10 : 2'b01) : 2'b00;
   assign rdata_o        = rst_ni ? mem_rdata_i : '0;
   assign err_o          = rst_ni & mem_err_i;
   assign protocol_err_o = protocol_err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sel_q          <= 1'b0;
         locked_q       <= 1'b0;
         count_q        <= '0;
         wptr_q         <= '0;
         rptr_q         <= '0;
         protocol_err_q <= 1'b0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) id_q[i] <= 1'b0;
`ifdef OBI_MEMORY_ARBITER_ROUND_ROBIN_EN
         prio_q         <= 1'b0;
`endif
      end else begin
         sel_q    <= sel_d;
         locked_q <= locked_d;
         count_q  <= count_d;
         if (accept) begin
            id_q[wptr_q] <= sel;
            wptr_q       <= next_ptr(wptr_q);
`ifdef OBI_MEMORY_ARBITER_ROUND_ROBIN_EN
            prio_q       <= ~sel;
`endif
         end
         if (pop) rptr_q <= next_ptr(rptr_q);
         if (mem_rvalid_i && count_q == '0) protocol_err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_obi_memory_arbiter.sv
// Directed-vector bench for obi_memory_arbiter with a queue-based transaction model
// checked every cycle, plus literal expectations taken from hand-worked scenarios.
module tb_obi_memory_arbiter;

   localparam int MAXO = 2;

   logic              clk = 1'b0;
   logic              rst_ni;
   logic [1:0]        req_i, gnt_o, we_i, rvalid_o;
   logic [1:0][31:0]  addr_i, wdata_i;
   logic [1:0][3:0]   be_i;
   logic [31:0]       rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic              err_o, mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i, protocol_err_o;
   logic [3:0]        mem_be_o;

   obi_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
      .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .protocol_err_o(protocol_err_o));

   always #5 clk = ~clk;

   int vecs = 0;
   int miscmp = 0;

   // Transaction-level model: queue of port IDs awaiting responses.
   int mq[$];
   bit mLocked, mLockPort, mPrio, mPerr;
   bit eSel, eMemReq, eAccept, ePop, ePerrSet;

   logic [1:0]  sGnt, sRvalid;
   logic [31:0] sAddr, sRdata;
   logic        sMemReq, sErr, sPerr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miscmp++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      mLocked = 0; mLockPort = 0; mPrio = 0; mPerr = 0;
   endtask

   task automatic applyStimulus(input bit rst, input logic [1:0] req, input logic [31:0] a0, a1,
                                input logic [1:0] we, input bit g, rv, input logic [31:0] rd, input bit er);
      rst_ni       = rst;
      req_i        = req;
      addr_i[0]    = a0;
      addr_i[1]    = a1;
      we_i         = we;
      wdata_i[0]   = 32'hA0A0_0000 ^ a0;
      wdata_i[1]   = 32'hB1B1_0000 ^ a1;
      be_i[0]      = 4'h3;
      be_i[1]      = 4'hC;
      mem_gnt_i    = g;
      mem_rvalid_i = rv;
      mem_rdata_i  = rd;
      mem_err_i    = er;
      if (!rst) modelReset();
   endtask

   task automatic checkOutput();
      logic [1:0] expGnt, expRv;
      sGnt = gnt_o; sRvalid = rvalid_o; sAddr = mem_addr_o; sRdata = rdata_o;
      sMemReq = mem_req_o; sErr = err_o; sPerr = protocol_err_o;
      if (!rst_ni) begin
         eAccept = 0; ePop = 0; ePerrSet = 0; eMemReq = 0;
         chk("rst_gnt", 32'(gnt_o), 0);
         chk("rst_mem_req", 32'(mem_req_o), 0);
         chk("rst_rvalid", 32'(rvalid_o), 0);
         chk("rst_perr", 32'(protocol_err_o), 0);
         chk("rst_addr", mem_addr_o, 0);
      end else begin
         if (mLocked) eSel = mLockPort;
`ifdef OBI_MEMORY_ARBITER_ROUND_ROBIN_EN
         else if (req_i == 2'b11) eSel = mPrio;
`endif
         else eSel = !req_i[0];
         eMemReq  = req_i[eSel] && (mq.size() < MAXO);
         eAccept  = eMemReq && mem_gnt_i;
         ePop     = mem_rvalid_i && (mq.size() > 0);
         ePerrSet = mem_rvalid_i && (mq.size() == 0);
         expGnt   = eAccept ? (eSel ? 2'b10 : 2'b01) : 2'b00;
         expRv    = ePop ? ((mq[0] == 1) ? 2'b10 : 2'b01) : 2'b00;
         chk("gnt", 32'(gnt_o), 32'(expGnt));
         chk("mem_req", 32'(mem_req_o), 32'(eMemReq));
         if (eMemReq) begin
            chk("mem_addr", mem_addr_o, addr_i[eSel]);
            chk("mem_we", 32'(mem_we_o), 32'(we_i[eSel]));
            chk("mem_be", 32'(mem_be_o), eSel ? 32'hC : 32'h3);
            chk("mem_wdata", mem_wdata_o, wdata_i[eSel]);
         end
         chk("rvalid", 32'(rvalid_o), 32'(expRv));
         if (ePop) begin
            chk("rdata", rdata_o, mem_rdata_i);
            chk("err", 32'(err_o), 32'(mem_err_i));
         end
         chk("perr", 32'(protocol_err_o), 32'(mPerr));
      end
   endtask

   task automatic modelUpdate();
      if (rst_ni) begin
         if (ePop) void'(mq.pop_front());
         if (eAccept) begin
            mq.push_back(int'(eSel));
            mPrio = !eSel;
         end
         if (ePerrSet) mPerr = 1;
         mLocked   = eMemReq && !mem_gnt_i;
         mLockPort = eSel;
      end
   endtask

   task automatic cyc(input bit rst, input logic [1:0] req, input logic [31:0] a0, a1,
                      input logic [1:0] we, input bit g, rv, input logic [31:0] rd, input bit er);
      applyStimulus(rst, req, a0, a1, we, g, rv, rd, er);
      #2;
      checkOutput();
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
   endtask

   task automatic resp(input logic [31:0] rd, input bit er);
      cyc(1, 2'b00, 0, 0, 2'b00, 0, 1, rd, er);
   endtask

   initial begin
      @(negedge clk);
      // Reset held with requests and memory activity present: all outputs low.
      cyc(0, 2'b11, 32'h100, 32'h200, 2'b00, 1, 1, 32'h55, 1);
      chk("lit_rst_gnt", 32'(sGnt), 0);
      chk("lit_rst_memreq", 32'(sMemReq), 0);
      cyc(0, 2'b11, 32'h100, 32'h200, 2'b00, 1, 1, 32'h55, 1);
      chk("lit_rst_rvalid", 32'(sRvalid), 0);
      chk("lit_rst_perr", 32'(sPerr), 0);

      // Single port-0 read with response two cycles later.
      cyc(1, 2'b01, 32'h100, 0, 2'b00, 1, 0, 0, 0);
      chk("lit_t1_gnt", 32'(sGnt), 32'h1);
      chk("lit_t1_addr", sAddr, 32'h100);
      idle();
      resp(32'hDEADBEEF, 0);
      chk("lit_t1_rvalid", 32'(sRvalid), 32'h1);
      chk("lit_t1_rdata", sRdata, 32'hDEADBEEF);

      // Interleaved port 0 then port 1, error on the second response.
      cyc(1, 2'b01, 32'h300, 0, 2'b00, 1, 0, 0, 0);
      cyc(1, 2'b10, 0, 32'h400, 2'b00, 1, 0, 0, 0);
      chk("lit_t4_gnt1", 32'(sGnt), 32'h2);
      resp(32'h1, 0);
      chk("lit_t4_rv0", 32'(sRvalid), 32'h1);
      chk("lit_t4_rd0", sRdata, 32'h1);
      resp(32'h2, 1);
      chk("lit_t4_rv1", 32'(sRvalid), 32'h2);
      chk("lit_t4_rd1", sRdata, 32'h2);
      chk("lit_t4_err", 32'(sErr), 32'h1);

      // Stalled grant: port-0 address held while port 1 changes its address.
      for (int i = 0; i < 3; i++) begin
         cyc(1, 2'b11, 32'h500, 32'h600 + 32'(i * 4), 2'b00, 0, 0, 0, 0);
         chk("lit_t2_addr", sAddr, 32'h500);
         chk("lit_t2_gnt", 32'(sGnt), 0);
      end
      cyc(1, 2'b11, 32'h500, 32'h60C, 2'b00, 1, 0, 0, 0);
      chk("lit_t2_addr4", sAddr, 32'h500);
      chk("lit_t2_gnt4", 32'(sGnt), 32'h1);
      cyc(1, 2'b10, 0, 32'h610, 2'b00, 1, 0, 0, 0);
      chk("lit_t2_gnt5", 32'(sGnt), 32'h2);
      resp(32'h7, 0);
      chk("lit_t2_rv0", 32'(sRvalid), 32'h1);
      resp(32'h8, 0);
      chk("lit_t2_rv1", 32'(sRvalid), 32'h2);

      // Port-1 writes against the outstanding limit.
      cyc(1, 2'b10, 0, 32'h700, 2'b10, 1, 0, 0, 0);
      chk("lit_t3_gnt_a", 32'(sGnt), 32'h2);
      cyc(1, 2'b10, 0, 32'h704, 2'b10, 1, 0, 0, 0);
      chk("lit_t3_gnt_b", 32'(sGnt), 32'h2);
      cyc(1, 2'b10, 0, 32'h708, 2'b10, 1, 0, 0, 0);
      chk("lit_t3_full_req", 32'(sMemReq), 0);
      chk("lit_t3_full_gnt", 32'(sGnt), 0);
      cyc(1, 2'b10, 0, 32'h708, 2'b10, 1, 1, 32'hA, 0);
      chk("lit_t3_pop_req", 32'(sMemReq), 0);
      chk("lit_t3_pop_rv", 32'(sRvalid), 32'h2);
      cyc(1, 2'b10, 0, 32'h708, 2'b10, 1, 0, 0, 0);
      chk("lit_t3_gnt_c", 32'(sGnt), 32'h2);
      resp(32'hB, 0);
      chk("lit_t3_rv_b", 32'(sRvalid), 32'h2);
      resp(32'hC, 0);
      chk("lit_t3_rv_c", 32'(sRvalid), 32'h2);

      // Response with nothing outstanding: sticky protocol error.
      resp(32'hF00, 0);
      chk("lit_t5_rv", 32'(sRvalid), 0);
      idle();
      chk("lit_t5_perr", 32'(sPerr), 1);
      idle();
      chk("lit_t5_perr_hold", 32'(sPerr), 1);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
      chk("lit_t5_perr_clr", 32'(sPerr), 0);

      // Continuous contention with immediate grants.
      for (int i = 0; i < 4; i++) begin
         cyc(1, 2'b11, 32'h800, 32'h900, 2'b00, 1, (i > 0), 32'(i), 0);
`ifdef OBI_MEMORY_ARBITER_ROUND_ROBIN_EN
         chk("lit_rr_gnt", 32'(sGnt), (i % 2 == 0) ? 32'h1 : 32'h2);
`else
         chk("lit_fp_gnt", 32'(sGnt), 32'h1);
`endif
      end
      resp(32'h44, 0);

      // Reset with a transaction outstanding discards it.
      cyc(1, 2'b01, 32'hA00, 0, 2'b00, 1, 0, 0, 0);
      cyc(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
      resp(32'h99, 0);
      chk("lit_mid_rv", 32'(sRvalid), 0);
      idle();
      chk("lit_mid_perr", 32'(sPerr), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule

// File: doc/obi_memory_arbiter.md
Name: obi_memory_arbiter

Overview:
- Shares one OBI memory port between two OBI requesters (port 0 = instruction fetch, port 1 = data) in the cv32e40x formal/simulation harness.
- Sequences address phases, holds the selection stable until grant, tracks outstanding transactions in order, and routes each response phase back to the requester that issued it.
- Sits between the core's OBI ports and the single-ported memory model.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions; must be ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  2  per-port OBI req
- gnt_o  out  2  per-port OBI gnt
- addr_i  in  2xADDR_WIDTH  per-port address
- we_i  in  2  per-port write enable
- be_i  in  2xDATA_WIDTH/8  per-port byte enables
- wdata_i  in  2xDATA_WIDTH  per-port write data
- rvalid_o  out  2  per-port response valid
- rdata_o  out  DATA_WIDTH  response data, shared by both ports; qualified by rvalid_o
- err_o  out  1  response error, shared; qualified by rvalid_o
- mem_req_o  out  1  memory req
- mem_gnt_i  in  1  memory gnt
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_WIDTH/8  memory byte enables
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_WIDTH  memory response data
- mem_err_i  in  1  memory response error
- protocol_err_o  out  1  sticky flag: rvalid received with no outstanding transaction

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_ni.
- State: sel_q (1b), locked_q (1b), prio_q (1b), count_q ($clog2(MAX_OUTSTANDING+1) bits), an ID FIFO of depth MAX_OUTSTANDING holding 1b port IDs, and protocol_err_q.
- Reset: all state cleared to 0. With rst_ni low, every output is 0 (mem_req_o, gnt_o, rvalid_o, protocol_err_o all 0).
- full = (count_q == MAX_OUTSTANDING).
- Selection:
  - If locked_q = 1: sel = sel_q.
  - Otherwise, fixed priority: port 0 if req_i[0], else port 1.
- Address phase:
  - mem_req_o = req_i[sel] & ~full.
  - mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are combinationally muxed from port sel.
  - gnt_o[sel] = mem_gnt_i & mem_req_o; gnt_o[other] = 0.
- Lock:
  - When mem_req_o = 1 and mem_gnt_i = 0: next locked_q = 1 and sel_q = sel, so the address phase stays stable until granted.
  - Lock clears on the grant cycle.
  - Lock also clears if the locked requester drops req, which is an OBI violation and is not otherwise flagged.
- Accept: when mem_req_o & mem_gnt_i, push sel into the ID FIFO.
- Response phase:
  - When mem_rvalid_i and count_q > 0: pop head ID h; rvalid_o[h] = 1; rdata_o = mem_rdata_i; err_o = mem_err_i. Responses are in order; latency is 0 cycles (combinational pass-through).
  - When mem_rvalid_i and count_q == 0: no rvalid_o; protocol_err_q set; it stays set until reset.
- Count:
  - +1 on accept, −1 on pop, unchanged on simultaneous accept and pop.
  - full is evaluated on count_q, so a pop in the same cycle does not unblock a request at full; the request proceeds one cycle later.
- Wrap-around: FIFO read/write pointers wrap modulo MAX_OUTSTANDING.
- Back-to-back: one accept per cycle is sustainable while not full.
- Reset mid-transaction: outstanding IDs are discarded. Responses arriving after reset set protocol_err_o.

Optional Feature:
- Macro: OBI_MEMORY_ARBITER_ROUND_ROBIN_EN.
- Defined: when unlocked and both req_i bits are high, sel = prio_q. On every accept, prio_q <= ~sel (the granted port becomes lowest priority).
- Undefined: prio_q is absent and fixed priority to port 0 applies.

Test Plan:
- Single port-0 read to addr 0x100, mem_gnt_i immediate, rvalid 2 cycles later with rdata 0xDEADBEEF -> gnt_o=01 in the request cycle; rvalid_o=01 with rdata_o=0xDEADBEEF; count returns to 0.
- Both ports request, mem_gnt_i held low 3 cycles -> mem_addr_o stays at port-0 address all 4 cycles even when port 1 changes its address; gnt_o=01 on cycle 4.
- MAX_OUTSTANDING=2, port 1 issues 3 back-to-back writes with no rvalid -> first two granted, mem_req_o=0 on the third; after one rvalid, third granted one cycle later; all 3 responses arrive on rvalid_o=10.
- Interleave: port 0 accepted, then port 1 accepted; two rvalids with rdata 0x1 then 0x2, mem_err_i=1 on the second -> rvalid_o=01 with rdata 0x1, then rvalid_o=10 with rdata 0x2 and err_o=1.
- mem_rvalid_i pulsed with count 0 -> rvalid_o=00; protocol_err_o=1 and held until rst_ni is asserted low.
- With OBI_MEMORY_ARBITER_ROUND_ROBIN_EN, both ports request continuously, gnt always high -> gnt_o alternates 01,10,01,10; without the macro -> gnt_o=01 every cycle.
